// File: rtl/frame_page_manager.sv
// frame_page_manager: 2/3-page SRAM frame buffer manager.
// Option: define FRAME_PAGE_VSYNC_LOCK_EN to lock flips to frame_start.
module frame_page_manager #(
  parameter int unsigned H_RES       = 800,
  parameter int unsigned V_RES       = 600,
  parameter int unsigned NUM_PAGES   = 2,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned BASE_OFFSET = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic              draw_done,
  input  logic [ADDR_W-1:0] sram_write_addr,
  output logic [ADDR_W-1:0] sram_read_address,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sram_write_address,
  output logic              draw_stall,
  output logic              page_flip,
  output logic [1:0]        disp_page,
  output logic [1:0]        draw_page
);

  localparam int unsigned PAGE_BITS =
    (NUM_PAGES == 3) ? 2 : 1;
  localparam int unsigned OFF_W =
    ADDR_W - PAGE_BITS;
  localparam int unsigned SUM_W =
    (OFF_W + 1 > 32) ? OFF_W + 1 : 32;

  if (NUM_PAGES != 2 && NUM_PAGES != 3) begin : g_bad_pages
    $error("frame_page_manager: NUM_PAGES must be 2 or 3");
  end

  if (64'(H_RES) * 64'(V_RES) + 64'(BASE_OFFSET)
      > (64'd1 << OFF_W)) begin : g_bad_size
    $error("frame_page_manager: frame does not fit in a page");
  end

  typedef enum logic {
    S_EMPTY,
    S_READY
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [1:0] disp_pg;
  logic [1:0] draw_pg;
  logic [1:0] spare_pg;
  logic [1:0] disp_n;
  logic [1:0] draw_n;
  logic [1:0] spare_n;
  logic       ready_vld;
  logic       flip;
  logic       take;
  logic       in_range;
  logic [OFF_W-1:0] off;
  logic       unused_wr;

  assign ready_vld = (state == S_READY);

`ifdef FRAME_PAGE_VSYNC_LOCK_EN
  assign flip = ready_vld && frame_start;
`else
  logic unused_fs;
  assign unused_fs = frame_start;
  assign flip = ready_vld;
`endif

  // Two pages: the finished page is frozen until it is shown.
  assign draw_stall =
    (NUM_PAGES == 2) && ready_vld;

  assign take = draw_done && !draw_stall;

  // Page rotation on renderer completion and flips.
  always_comb begin
    disp_n  = disp_pg;
    draw_n  = draw_pg;
    spare_n = spare_pg;
    state_n = state;
    if (NUM_PAGES == 3) begin
      unique case (1'b1)
        flip && take: begin
          disp_n  = spare_pg;
          draw_n  = disp_pg;
          spare_n = draw_pg;
          state_n = S_READY;
        end
        flip && !take: begin
          disp_n  = spare_pg;
          spare_n = disp_pg;
          state_n = S_EMPTY;
        end
        !flip && take: begin
          draw_n  = spare_pg;
          spare_n = draw_pg;
          state_n = S_READY;
        end
        default: ;
      endcase
    end else begin
      unique case (1'b1)
        flip: begin
          disp_n  = draw_pg;
          draw_n  = disp_pg;
          state_n = S_EMPTY;
        end
        take: begin
          state_n = S_READY;
        end
        default: ;
      endcase
    end
  end

  // Page and handshake state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= S_EMPTY;
      disp_pg   <= 2'd0;
      draw_pg   <= 2'd1;
      spare_pg  <= 2'd2;
      page_flip <= 1'b0;
    end else begin
      state     <= state_n;
      disp_pg   <= disp_n;
      draw_pg   <= draw_n;
      spare_pg  <= spare_n;
      page_flip <= flip;
    end
  end

  assign in_range =
    (32'(DrawX) < H_RES) &&
    (32'(DrawY) < V_RES);

  assign off = OFF_W'(
    SUM_W'(DrawX) +
    SUM_W'(DrawY) * SUM_W'(H_RES) +
    SUM_W'(BASE_OFFSET));

  // Display read address, one cycle behind the scan position.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sram_read_address <= '0;
      rd_valid          <= 1'b0;
    end else if (in_range) begin
      sram_read_address <=
        {disp_pg[PAGE_BITS-1:0], off};
      rd_valid <= 1'b1;
    end else begin
      sram_read_address <=
        {disp_pg[PAGE_BITS-1:0], {OFF_W{1'b0}}};
      rd_valid <= 1'b0;
    end
  end

  assign sram_write_address =
    {draw_pg[PAGE_BITS-1:0],
     sram_write_addr[OFF_W-1:0]};

  assign unused_wr =
    ^sram_write_addr[ADDR_W-1:OFF_W];

  assign disp_page = disp_pg;
  assign draw_page = draw_pg;

endmodule

// File: tb/tb_frame_page_manager.sv
// tb_frame_page_manager: 2-page 800x600 and 3-page 320x240
// instances checked against a page-role model every cycle.
module tb_frame_page_manager;

`ifdef FRAME_PAGE_VSYNC_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic        draw_done;
  logic [19:0] wa;

  logic [19:0] a_rd, a_wr, b_rd, b_wr;
  logic        a_rv, a_stall, a_flip;
  logic        b_rv, b_stall, b_flip;
  logic [1:0]  a_disp, a_draw, b_disp, b_draw;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  int a_flips = 0;
  int b_flips = 0;

  always #5 Clk = ~Clk;

  frame_page_manager u_a (
    .Clk(Clk), .Reset_n(Reset_n),
    .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .draw_done(draw_done),
    .sram_write_addr(wa),
    .sram_read_address(a_rd), .rd_valid(a_rv),
    .sram_write_address(a_wr), .draw_stall(a_stall),
    .page_flip(a_flip), .disp_page(a_disp),
    .draw_page(a_draw)
  );

  frame_page_manager #(
    .H_RES(320), .V_RES(240), .NUM_PAGES(3)
  ) u_b (
    .Clk(Clk), .Reset_n(Reset_n),
    .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .draw_done(draw_done),
    .sram_write_addr(wa),
    .sram_read_address(b_rd), .rd_valid(b_rv),
    .sram_write_address(b_wr), .draw_stall(b_stall),
    .page_flip(b_flip), .disp_page(b_disp),
    .draw_page(b_draw)
  );

  typedef struct {
    int     disp;
    int     draw;
    int     spare;
    bit     ready;
    bit     stall;
    bit     flip;
    longint rd;
    bit     rv;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t rst_state();
    mdl_t r;
    r.disp = 0; r.draw = 1; r.spare = 2;
    r.ready = 0; r.stall = 0; r.flip = 0;
    r.rd = 0; r.rv = 0;
    return r;
  endfunction

  // One clock of the page-role rules.
  function automatic mdl_t step(mdl_t s, int np, int h, int v,
                                int ow, bit fs, bit dd,
                                int x, int y);
    mdl_t n = s;
    bit show = s.ready && (fs || !LOCK);
    bit acc = dd && !s.stall;
    n.flip = show;
    if (np == 2) begin
      if (show) begin
        n.disp = s.draw; n.draw = s.disp;
        n.ready = 0; n.stall = 0;
      end else if (acc) begin
        n.ready = 1; n.stall = 1;
      end
    end else begin
      if (show && acc) begin
        n.disp = s.spare; n.draw = s.disp;
        n.spare = s.draw; n.ready = 1;
      end else if (show) begin
        n.disp = s.spare; n.spare = s.disp; n.ready = 0;
      end else if (acc) begin
        n.draw = s.spare; n.spare = s.draw; n.ready = 1;
      end
    end
    if (x < h && y < v) begin
      n.rd = (longint'(s.disp) << ow) +
             longint'((x + y * h + 1) % (1 << ow));
      n.rv = 1;
    end else begin
      n.rd = longint'(s.disp) << ow;
      n.rv = 0;
    end
    return n;
  endfunction

  always @(posedge Clk) begin
    if (!Reset_n) begin
      ma <= rst_state();
      mb <= rst_state();
    end else begin
      ma <= step(ma, 2, 800, 600, 19, frame_start, draw_done,
                 int'(DrawX), int'(DrawY));
      mb <= step(mb, 3, 320, 240, 18, frame_start, draw_done,
                 int'(DrawX), int'(DrawY));
    end
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (chk_on) begin
      chk("a_disp", 64'(a_disp), 64'(ma.disp));
      chk("a_draw", 64'(a_draw), 64'(ma.draw));
      chk("a_stall", 64'(a_stall), 64'(ma.stall));
      chk("a_flip", 64'(a_flip), 64'(ma.flip));
      chk("a_rd", 64'(a_rd), 64'(ma.rd));
      chk("a_rv", 64'(a_rv), 64'(ma.rv));
      chk("a_wr", 64'(a_wr),
          64'((longint'(ma.draw) << 19) | longint'(wa[18:0])));
      chk("b_disp", 64'(b_disp), 64'(mb.disp));
      chk("b_draw", 64'(b_draw), 64'(mb.draw));
      chk("b_stall", 64'(b_stall), 64'(0));
      chk("b_flip", 64'(b_flip), 64'(mb.flip));
      chk("b_rd", 64'(b_rd), 64'(mb.rd));
      chk("b_rv", 64'(b_rv), 64'(mb.rv));
      chk("b_wr", 64'(b_wr),
          64'((longint'(mb.draw) << 18) | longint'(wa[17:0])));
      if (a_flip === 1'b1) a_flips++;
      if (b_flip === 1'b1) b_flips++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; draw_done = 1'b0;
    DrawX = '0; DrawY = '0; wa = '0;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_disp", 64'(a_disp), 64'd0);
    chk("rst_draw", 64'(a_draw), 64'd1);
    chk("rst_stall", 64'(a_stall), 64'd0);
    chk("rst_flip", 64'(a_flip), 64'd0);
    chk("rst_rd", 64'(a_rd), 64'd0);
    chk("rst_rv", 64'(a_rv), 64'd0);

    Reset_n = 1'b1; DrawX = 10'd5; DrawY = 10'd2; wa = 20'd10;
    tick();
    chk("rd_5_2", 64'(a_rd), 64'd1606);
    chk("rv_5_2", 64'(a_rv), 64'd1);
    chk("wr_10", 64'(a_wr), 64'd524298);
    chk("b_rd_5_2", 64'(b_rd), 64'd646);

    DrawX = 10'd800; DrawY = 10'd0;
    tick();
    chk("rv_800", 64'(a_rv), 64'd0);
    chk("rd_800", 64'(a_rd), 64'd0);
    DrawX = 10'd5; DrawY = 10'd2;

    draw_done = 1'b1; tick(); draw_done = 1'b0;
    chk("stall_set", 64'(a_stall), 64'd1);
    chk("b_draw_1st", 64'(b_draw), 64'd2);
    tick(); tick(); tick();
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    tick(); tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
`ifdef FRAME_PAGE_VSYNC_LOCK_EN
    chk("fs_flip", 64'(a_flip), 64'd1);
    chk("fs_a_disp", 64'(a_disp), 64'd1);
    chk("fs_a_draw", 64'(a_draw), 64'd0);
    chk("fs_b_disp", 64'(b_disp), 64'd2);
    chk("fs_b_draw", 64'(b_draw), 64'd1);
    chk("a_flip_cnt", 64'(a_flips), 64'd1);
    chk("b_flip_cnt", 64'(b_flips), 64'd1);
    tick();
    chk("rd_new_pg", 64'(a_rd), 64'd525894);
`else
    chk("fs_flip", 64'(a_flip), 64'd0);
    chk("fs_a_disp", 64'(a_disp), 64'd0);
    chk("fs_a_draw", 64'(a_draw), 64'd1);
    chk("fs_b_disp", 64'(b_disp), 64'd2);
    chk("fs_b_draw", 64'(b_draw), 64'd0);
    chk("a_flip_cnt", 64'(a_flips), 64'd2);
    chk("b_flip_cnt", 64'(b_flips), 64'd2);
    tick();
    chk("rd_new_pg", 64'(a_rd), 64'd1606);
`endif

    draw_done = 1'b1; tick();
    frame_start = 1'b1; tick();
    draw_done = 1'b0; frame_start = 1'b0;
`ifdef FRAME_PAGE_VSYNC_LOCK_EN
    chk("coin_b_disp", 64'(b_disp), 64'd1);
`else
    chk("coin_b_disp", 64'(b_disp), 64'd0);
`endif
    chk("coin_b_draw", 64'(b_draw), 64'd2);
    tick(); tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
`ifdef FRAME_PAGE_VSYNC_LOCK_EN
    chk("kept_ready", 64'(b_disp), 64'd0);
`else
    chk("kept_ready", 64'(b_disp), 64'd1);
`endif

    draw_done = 1'b1; tick(); draw_done = 1'b0;
    chk("stall_mid", 64'(a_stall), 64'd1);
    Reset_n = 1'b0; tick(); Reset_n = 1'b1;
    chk("mrst_disp", 64'(a_disp), 64'd0);
    chk("mrst_draw", 64'(a_draw), 64'd1);
    chk("mrst_stall", 64'(a_stall), 64'd0);
    chk("mrst_flip", 64'(a_flip), 64'd0);
    chk("mrst_rv", 64'(a_rv), 64'd0);
    chk("mrst_b_draw", 64'(b_draw), 64'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    chk("discard_disp", 64'(a_disp), 64'd0);
    chk("discard_b", 64'(b_disp), 64'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_page_manager.md
# frame_page_manager

Parametrised successor to the two-page SRAM frame-buffer address splitter. It sits between the VGA scan counters, the renderer's SRAM write port and the SRAM controller. It manages 2 or 3 frame pages: one display page, one draw page and, with 3 pages, one ready/free page. A renderer handshake drives page flips, and flips are optionally locked to the frame boundary so the display never tears.

## Interface
Parameters:
- H_RES, 800, visible pixels per line
- V_RES, 600, visible lines per frame
- NUM_PAGES, 2, page count; legal values 2 or 3
- ADDR_W, 20, SRAM address width
- BASE_OFFSET, 1, constant added to every pixel offset

Derived values:
- PAGE_BITS = 1 for 2 pages, 2 for 3 pages
- OFF_W = ADDR_W − PAGE_BITS
- Elaboration error if H_RES·V_RES + BASE_OFFSET > 2^OFF_W

Ports:
- Clk  in  1  system clock; one clock, all state on rising edge
- Reset_n  in  1  reset, synchronous, active-low
- DrawX  in  10  scan column
- DrawY  in  10  scan row
- frame_start  in  1  one-cycle pulse at start of vertical blank
- draw_done  in  1  one-cycle pulse: renderer finished current draw page
- sram_write_addr  in  ADDR_W  renderer pixel offset; low OFF_W bits used
- sram_read_address  out  ADDR_W  registered display read address
- rd_valid  out  1  registered; 1 when the pixel is inside the visible area
- sram_write_address  out  ADDR_W  combinational {draw_pg, sram_write_addr[OFF_W-1:0]}
- draw_stall  out  1  renderer must not write or pulse draw_done
- page_flip  out  1  one-cycle pulse when disp_pg changes
- disp_page  out  2  current display page index
- draw_page  out  2  current draw page index

## Operation
Internal state:
- disp_pg, draw_pg, spare_pg (3-page mode only)
- ready_vld flag

Read path:
- off = DrawX + DrawY·H_RES + BASE_OFFSET, computed in unsigned arithmetic of at least OFF_W+1 bits, then truncated to OFF_W.
- In range (DrawX < H_RES and DrawY < V_RES): registered sram_read_address = {disp_pg, off}, rd_valid = 1.
- Out of range: sram_read_address = {disp_pg, 0}, rd_valid = 0.

draw_done when NUM_PAGES = 2:
- Sets ready_vld = 1 and draw_stall = 1.
- The draw page is now the pending page.

draw_done when NUM_PAGES = 3:
- If !ready_vld: spare_pg ← draw_pg, draw_pg ← old spare_pg, ready_vld ← 1.
- If ready_vld (newest frame wins): swap draw_pg and spare_pg; the stale ready frame is recycled as the draw page. ready_vld stays 1.
- draw_stall is never asserted in 3-page mode.

draw_done while draw_stall = 1 is ignored.

Flip (when the flip condition holds and ready_vld = 1):
- 2-page mode: disp_pg ↔ draw_pg swap, ready_vld ← 0, draw_stall ← 0.
- 3-page mode: disp_pg ← spare_pg, spare_pg ← old disp_pg, ready_vld ← 0.
- page_flip pulses for one cycle.

Simultaneous events:
- The flip decision uses ready_vld as registered before the current edge.
- 2-page mode: draw_done in the same cycle as frame_start does not flip until the next flip condition.
- 3-page mode, draw_done and flip in the same cycle: the flip consumes the old ready page (disp ← old spare). The draw page becomes the new ready page, and draw_pg ← old disp_pg. ready_vld ends at 1.

## Timing
- Reset (Reset_n = 0 at an edge):
  - disp_pg = 0, draw_pg = 1, spare_pg = 2
  - ready_vld = 0, draw_stall = 0, page_flip = 0
  - sram_read_address = 0, rd_valid = 0
- Reset mid-frame discards any pending ready frame.
- sram_read_address and rd_valid: 1 cycle latency from DrawX/DrawY.
- A flip at edge N changes disp_page after edge N. sram_read_address reflects the new page after edge N+1.
- draw_stall asserts the cycle after the draw_done edge. It deasserts the cycle after the flip edge.
- sram_write_address follows draw_pg with zero latency, so it changes the cycle after draw_done or flip.

## Configuration
- FRAME_PAGE_VSYNC_LOCK_EN defined:
  - Flip condition = frame_start && ready_vld.
  - Tear-free display.
- FRAME_PAGE_VSYNC_LOCK_EN undefined:
  - Flip condition = ready_vld; frame_start is ignored.
  - A flip occurs the cycle after ready_vld rises (tearing allowed, lowest latency).
  - 2-page stall lasts exactly 1 cycle.

## Test plan
- Reset, then DrawX = 5, DrawY = 2, defaults:
  - Next cycle sram_read_address = 1606, rd_valid = 1.
  - sram_write_addr = 10 → sram_write_address = 0x80000 + 10 = 524298.
- DrawX = 800, DrawY = 0 → rd_valid = 0 and sram_read_address = 0 one cycle later.
- 2 pages, VSYNC_LOCK_EN defined, draw_done pulse:
  - draw_stall = 1 until frame_start.
  - Then page_flip = 1 for one cycle, disp_page = 1, draw_page = 0, draw_stall = 0.
  - Read of (5, 2) afterwards = 0x80000 + 1606.
- 3 pages, H_RES = 320, V_RES = 240:
  - Two draw_done pulses before frame_start → draw_page 1→2→1, one page_flip.
  - disp_page = 2 after frame_start; draw_stall never asserted.
- 3 pages, draw_done coincident with frame_start while ready_vld = 1:
  - disp_pg ← old spare.
  - draw_pg ← old disp.
  - spare_pg ← old draw.
  - ready_vld remains 1.
- Reset_n low for one cycle mid-stall:
  - All outputs return to reset values at the next edge, with disp_page = 0 and draw_page = 1.
